// File: rtl/hdlc_tx_ctrl.sv
// hdlc_tx_ctrl: serial HDLC-style frame sequencer with zero insertion and RS-485 driver-enable control.
module hdlc_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int LEAD_BITS = 2,
  parameter int TAIL_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        abort,
  output logic        tx_out,
  output logic        tx_de,
  output logic        busy,
  output logic [3:0]  stuff_cnt,
  output logic        frame_done,
  output logic        aborted
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_LEAD = 3'd1, S_OPEN = 3'd2, S_PAY = 3'd3,
                         S_CLOSE = 3'd4, S_TAIL = 3'd5, S_ABORT = 3'd6;
  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [7:0]    idx;
  logic [2:0]    ones;
  logic [39:0]   sreg;
  logic          from_abort;
  logic          last;
  logic          flag_bit;
  logic          can_abort;
  assign last      = timer == T_LAST;
  assign flag_bit  = idx[2:0] != 3'd0 && idx[2:0] != 3'd7;
  assign can_abort = state == S_OPEN || state == S_PAY || state == S_CLOSE;
  assign tx_ready  = state == S_IDLE;
  assign tx_de     = state != S_IDLE;
  assign busy      = state != S_IDLE;
  always_comb begin
    tx_out = (state == S_OPEN || state == S_CLOSE) ? flag_bit :
             (state == S_PAY) ? (ones != 3'd5 && sreg[39]) : 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      idx        <= '0;
      ones       <= '0;
      sreg       <= '0;
      from_abort <= 1'b0;
      stuff_cnt  <= '0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      aborted    <= 1'b0;
      if (state == S_IDLE) begin
        if (tx_valid) begin
          sreg       <= tx_data;
          stuff_cnt  <= '0;
          ones       <= '0;
          from_abort <= 1'b0;
          timer      <= '0;
          idx        <= '0;
          state      <= S_LEAD;
        end
      end else begin
        timer <= last ? '0 : timer + 1'b1;
        if (last && abort && can_abort) begin
          state      <= S_ABORT;
          idx        <= '0;
          from_abort <= 1'b1;
        end else if (last) begin
          idx <= idx + 1'b1;
          case (state)
            S_LEAD: if (idx == 8'(LEAD_BITS - 1)) begin
              state <= S_OPEN;
              idx   <= '0;
            end
            S_OPEN: if (idx == 8'd7) begin
              state <= S_PAY;
              idx   <= '0;
            end
            S_PAY: begin
              // idx counts data bits only; a stuffed zero leaves it and the shifter untouched
              if (ones == 3'd5) begin
                idx       <= idx;
                ones      <= '0;
                stuff_cnt <= stuff_cnt + 4'd1;
                if (idx == 8'd40) begin
                  state <= S_CLOSE;
                  idx   <= '0;
                end
              end else begin
                sreg <= {sreg[38:0], 1'b0};
                ones <= sreg[39] ? ones + 3'd1 : 3'd0;
                if (idx == 8'd39 && !(sreg[39] && ones == 3'd4)) begin
                  state <= S_CLOSE;
                  idx   <= '0;
                end
              end
            end
            S_CLOSE: if (idx == 8'd7) begin
              state <= S_TAIL;
              idx   <= '0;
            end
            S_ABORT: if (idx == 8'd7) begin
              state <= S_TAIL;
              idx   <= '0;
            end
            S_TAIL: if (idx == 8'(TAIL_BITS - 1)) begin
              state      <= S_IDLE;
              idx        <= '0;
              frame_done <= !from_abort;
              aborted    <= from_abort;
            end
            default: begin
              state <= S_IDLE;
              idx   <= '0;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_hdlc_tx_ctrl.sv
// tb_hdlc_tx_ctrl: directed and randomized frames checked against a bit-list model of the frame format.
module tb_hdlc_tx_ctrl;
  localparam int CPB = 16;
  localparam int LB = 2;
  localparam int TLB = 2;
  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        abort;
  logic        tx_out;
  logic        tx_de;
  logic        busy;
  logic [3:0]  stuff_cnt;
  logic        frame_done;
  logic        aborted;
  int errs = 0;
  int checks = 0;
  logic [127:0] exp_v;
  int exp_n;
  int exp_stuff;
  int got_n;

  hdlc_tx_ctrl #(.CLKS_PER_BIT(CPB), .LEAD_BITS(LB), .TAIL_BITS(TLB)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .abort(abort), .tx_out(tx_out), .tx_de(tx_de), .busy(busy), .stuff_cnt(stuff_cnt),
    .frame_done(frame_done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line bits of a whole frame; an abort after bit ab replaces the rest with 8+TAIL ones.
  function automatic void build(input logic [39:0] d, input int ab);
    bit q[$];
    int spos[$];
    int run = 0;
    bit flag[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    for (int i = 0; i < LB; i++) q.push_back(1'b1);
    for (int i = 0; i < 8; i++) q.push_back(flag[i]);
    for (int i = 39; i >= 0; i--) begin
      q.push_back(d[i]);
      run = d[i] ? run + 1 : 0;
      if (run == 5) begin
        spos.push_back(q.size());
        q.push_back(1'b0);
        run = 0;
      end
    end
    for (int i = 0; i < 8; i++) q.push_back(flag[i]);
    for (int i = 0; i < TLB; i++) q.push_back(1'b1);
    if (ab >= 0) begin
      while (q.size() > ab + 1) void'(q.pop_back());
      for (int i = 0; i < 8 + TLB; i++) q.push_back(1'b1);
    end
    exp_stuff = 0;
    foreach (spos[i]) if (ab < 0 || spos[i] <= ab) exp_stuff++;
    exp_n = q.size();
    exp_v = '0;
    foreach (q[i]) exp_v = {exp_v[126:0], q[i]};
  endfunction

  task automatic run_frame(input logic [39:0] d, input int ab, input bit hold, input string tag);
    logic [127:0] got_v = '0;
    int bad = 0, de_cyc = 0, pulses = 0, c = 0;
    got_n = 0;
    build(d, ab);
    tx_data = d;
    tx_valid = 1'b1;
    chk({tag, ":ready"}, tx_ready, 1);
    @(posedge clk);
    #1 tx_valid = hold;
    while (1) begin
      @(negedge clk);
      if (!tx_de || c >= 4000) break;
      de_cyc++;
      if (busy !== 1'b1 || tx_ready !== 1'b0) bad++;
      if (frame_done || aborted) pulses++;
      if (c % CPB == CPB / 2) begin
        got_v = {got_v[126:0], tx_out};
        got_n++;
      end else if ((c % CPB == 0 || c % CPB == CPB - 1) && c / CPB < exp_n) begin
        if (tx_out !== exp_v[exp_n - 1 - c / CPB]) bad++;
      end
      abort = ab >= 0 && c >= ab * CPB + CPB / 2 && c < ab * CPB + CPB / 2 + CPB;
      c++;
    end
    abort = 1'b0;
    chk({tag, ":bits"}, got_v, exp_v);
    chk({tag, ":nbits"}, got_n, exp_n);
    chk({tag, ":de_cycles"}, de_cyc, exp_n * CPB);
    chk({tag, ":in_bit"}, bad, 0);
    chk({tag, ":early_pulse"}, pulses, 0);
    chk({tag, ":done_abrt"}, {frame_done, aborted}, {ab < 0, ab >= 0});
    chk({tag, ":stuff"}, stuff_cnt, exp_stuff);
    chk({tag, ":idle_out"}, {tx_out, tx_ready, busy}, 3'b110);
  endtask

  initial begin
    logic [63:0] r;
    int ab, w;
    rst = 1'b0;
    tx_valid = 1'b0;
    abort = 1'b0;
    tx_data = '0;
    #12;
    chk("reset_outs", {tx_out, tx_de, busy, tx_ready, stuff_cnt, frame_done, aborted}, {4'b1001, 4'd0, 2'b00});
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("post_reset", {tx_out, tx_de, tx_ready}, 3'b101);

    run_frame(40'hFFFFFFFFFF, -1, 0, "all_ones");
    chk("all_ones:stuff8", stuff_cnt, 8);
    chk("all_ones:len", got_n, 68);
    run_frame(40'hFA4A52A53F, -1, 0, "mixed");
    chk("mixed:stuff2", stuff_cnt, 2);
    chk("mixed:len", got_n, 62);
    run_frame(40'h000000001F, -1, 0, "tail_stuff");
    chk("tail_stuff:stuff1", stuff_cnt, 1);

    run_frame(40'h0, -1, 1, "zero_hold");
    chk("zero_hold:len", got_n, 60);
    @(negedge clk);
    chk("b2b:de_rise", {tx_de, tx_ready}, 2'b10);
    tx_valid = 1'b0;
    w = 0;
    while (tx_de && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("b2b:len", w, 60 * CPB);
    chk("b2b:done", {frame_done, stuff_cnt}, {1'b1, 4'd0});

    run_frame(40'hFFFF00FFFF, LB + 8 + 12, 0, "abort_pay");

    tx_data = 40'hA5A5A5A5A5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat ((LB + 4) * CPB) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid", {tx_out, tx_de, busy, tx_ready, stuff_cnt, frame_done, aborted}, {4'b1001, 4'd0, 2'b00});
    @(negedge clk) rst = 1'b1;
    w = 0;
    repeat (3) begin
      @(negedge clk);
      if (tx_de || frame_done || aborted || !tx_out) w++;
    end
    chk("rst_quiet", w, 0);
    run_frame(40'h123456789A, -1, 0, "after_rst");

    for (int i = 0; i < 10; i++) begin
      r = {$urandom, $urandom};
      if (i % 2 == 1) r = r | {$urandom, $urandom};
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(LB + 8, LB + 8 + 39)) : -1;
      run_frame(r[39:0], ab, 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
